// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared FSM state, default sizes and stats helpers for fifo_wr_arbiter
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_WIDTH = 16;
    localparam int STATS_W        = 16;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker starting after last_idx
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int SW = IDX_W + 1;

    logic          found;
    logic [SW-1:0] s;
    logic [NUM_REQ-1:0] mask;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        s         = '0;
        mask      = '0;
        // Walk candidates last+1 .. last+NUM_REQ, wrapping modulo NUM_REQ.
        for (int k = 1; k <= NUM_REQ; k++) begin
            s = {1'b0, last_idx} + SW'(k);
            if (s >= SW'(NUM_REQ)) begin
                s = s - SW'(NUM_REQ);
            end
            mask = NUM_REQ'(1) << s;
            if (!found && ((req & mask) != '0)) begin
                found     = 1'b1;
                grant     = mask;
                grant_idx = s[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin N-to-1 FIFO write arbiter; FIFO_ARB_STATS_EN adds grant/drop counters
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          err_drop
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0]    grant_cnt,
    output logic [STATS_W-1:0]            drop_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_q;
    logic [IDX_W-1:0]       last_q;
    logic                   wr_en_q;
    logic                   pend_q;
    logic [FIFO_WIDTH-1:0]  data_q;
    logic [FIFO_WIDTH-1:0]  data_d;
    logic [NUM_REQ-1:0]     pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   space;
    logic                   any_req;
    logic                   do_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req       (req),
        .last_idx  (last_q),
        .grant     (pick_gnt),
        .grant_idx (pick_idx)
    );

    // An almost-full FIFO can absorb only the write already in flight.
    assign space    = !fifo_full && !(fifo_almostfull && wr_en_q);
    assign any_req  = |req;
    assign do_grant = !rst && space && any_req;
    assign grant    = do_grant ? pick_gnt : '0;

    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                data_d = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            wr_en_q <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!space)       state_q <= STALL;
                    else if (any_req) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (!space)        state_q <= STALL;
                    else if (!any_req) state_q <= IDLE;
                end
                STALL: begin
                    if (space) state_q <= any_req ? ACTIVE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (do_grant) begin
                last_q <= pick_idx;
            end
            wr_en_q <= do_grant;
            pend_q  <= wr_en_q;
            data_q  <= data_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_data_in = data_q;
    // The ack for a write issued in cycle t is due in t+1.
    assign err_drop     = !rst && ((pend_q && !fifo_wr_ack) || fifo_overflow);

`ifdef FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] gcnt_q [NUM_REQ];
    logic [STATS_W-1:0] dcnt_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
        always_ff @(posedge clk) begin
            if (rst) begin
                gcnt_q[g] <= '0;
            end else if (grant[g]) begin
                gcnt_q[g] <= sat_inc(gcnt_q[g]);
            end
        end
        assign grant_cnt[g*STATS_W +: STATS_W] = gcnt_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
        end else if (err_drop) begin
            dcnt_q <= sat_inc(dcnt_q);
        end
    end

    assign drop_cnt = dcnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic        fifo_wr_en;
    logic [15:0] fifo_data_in;
    logic        fifo_full;
    logic        fifo_almostfull;
    logic        fifo_wr_ack = 1'b0;
    logic        fifo_overflow;
    logic        err_drop;
    logic        kill_ack = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] grant_cnt;
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .grant           (grant),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .err_drop        (err_drop)
`ifdef FIFO_ARB_STATS_EN
        ,
        .grant_cnt       (grant_cnt),
        .drop_cnt        (drop_cnt)
`endif
    );

    // Compliant FIFO: acks every write one cycle later unless told to drop it.
    always @(posedge clk) fifo_wr_ack <= fifo_wr_en && !kill_ack;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'hF;
        step();
        step();
        @(negedge clk);
        checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
        checks++; if (fifo_data_in !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", fifo_data_in); end
        checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_drop); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        step();
        rst = 1'b0;
        req = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp_g = 4'b0001 << (c % 4);
            checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, grant, exp_g); end
            checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL rr_err c=%0d got=%b exp=0", c, err_drop); end
            if (c == 0) begin
                checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rr_wr_en0 got=%b exp=0", fifo_wr_en); end
            end else begin
                exp_d = 16'h1000 + 16'((c - 1) % 4);
                checks++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== exp_d) begin
                    failures++; $display("FAIL rr_data c=%0d got=%b/%h exp=1/%h", c, fifo_wr_en, fifo_data_in, exp_d);
                end
            end
            step();
        end
        req = 4'h0;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'h1000 || grant !== 4'b0) begin
            failures++; $display("FAIL rr_tail got=%b/%h/%b exp=1/1000/0000", fifo_wr_en, fifo_data_in, grant);
        end
        step();
    endtask

    task automatic test_single();
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", grant); end
        step();
        req = 4'b0000;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA5A5) begin
            failures++; $display("FAIL single_data got=%b/%h exp=1/a5a5", fifo_wr_en, fifo_data_in);
        end
        step();
    endtask

    task automatic test_almostfull();
        req = 4'b0001;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL af_first got=%b exp=0001", grant); end
        step();
        fifo_almostfull = 1'b1;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || grant !== 4'b0000) begin
            failures++; $display("FAIL af_block got=%b/%b exp=1/0000", fifo_wr_en, grant);
        end
        step();
        @(negedge clk);
        checks++; if (dut.state_q !== STALL) begin failures++; $display("FAIL af_state got=%0d exp=%0d", dut.state_q, STALL); end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL af_resume got=%b exp=0001", grant); end
        step();
        fifo_almostfull = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0001 || dut.state_q !== ACTIVE) begin
            failures++; $display("FAIL af_clear got=%b/%0d exp=0001/%0d", grant, dut.state_q, ACTIVE);
        end
        step();
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_full();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        fifo_full = 1'b1;
        req = 4'b0101;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL full_hold c=%0d got=%b exp=0000", c, grant); end
            if (c == 9) begin
                checks++; if (dut.state_q !== STALL) begin failures++; $display("FAIL full_state got=%0d exp=%0d", dut.state_q, STALL); end
            end
            step();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL full_rel0 got=%b exp=0001", grant); end
        step();
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100 || fifo_data_in !== 16'h1000) begin
            failures++; $display("FAIL full_rel2 got=%b/%h exp=0100/1000", grant, fifo_data_in);
        end
        step();
        req = 4'b0000;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA5A5) begin
            failures++; $display("FAIL full_data2 got=%b/%h exp=1/a5a5", fifo_wr_en, fifo_data_in);
        end
        step();
    endtask

    task automatic test_drop();
        req = 4'b0010;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL drop_grant got=%b exp=0010", grant); end
        step();
        req = 4'b0000;
        kill_ack = 1'b1;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || err_drop !== 1'b0) begin
            failures++; $display("FAIL drop_pre got=%b/%b exp=1/0", fifo_wr_en, err_drop);
        end
        step();
        kill_ack = 1'b0;
        @(negedge clk);
        checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", err_drop); end
        step();
        @(negedge clk);
        checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL drop_end got=%b exp=0", err_drop); end
`ifdef FIFO_ARB_STATS_EN
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
        step();
        fifo_overflow = 1'b1;
        @(negedge clk);
        checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", err_drop); end
        step();
        fifo_overflow = 1'b0;
        @(negedge clk);
        checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL ovf_end got=%b exp=0", err_drop); end
        step();
    endtask

    task automatic test_reset_mid();
        req = 4'hF;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL rm_grant got=%b exp=0100", grant); end
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0000 || err_drop !== 1'b0) begin
            failures++; $display("FAIL rm_inrst got=%b/%b exp=0000/0", grant, err_drop);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b0 || err_drop !== 1'b0) begin
            failures++; $display("FAIL rm_cancel got=%b/%b exp=0/0", fifo_wr_en, err_drop);
        end
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL rm_prio got=%b exp=0001", grant); end
        step();
        req = 4'h0;
        @(negedge clk);
        checks++; if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'h1000 || err_drop !== 1'b0) begin
            failures++; $display("FAIL rm_write got=%b/%h/%b exp=1/1000/0", fifo_wr_en, fifo_data_in, err_drop);
        end
        step();
        @(negedge clk);
        checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL rm_ack got=%b exp=0", err_drop); end
    endtask

    initial begin
        rst             = 1'b1;
        req             = 4'h0;
        req_data        = {16'h1003, 16'hA5A5, 16'h1001, 16'h1000};
        fifo_full       = 1'b0;
        fifo_almostfull = 1'b0;
        fifo_overflow   = 1'b0;
        test_reset();
        req_data[47:32] = 16'h1002;
        test_round_robin();
        req_data[47:32] = 16'hA5A5;
        test_single();
        test_almostfull();
        test_full();
        test_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter FIFO_WIDTH, default 16, data width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req, input, NUM_REQ, per-requester write request, held until granted.
REQ-006 SHALL have port req_data, input, NUM_REQ*FIFO_WIDTH, requester i data in slice i.
REQ-007 SHALL have port grant, output, NUM_REQ, one-hot accept pulse, combinational, same cycle as capture.
REQ-008 SHALL have port fifo_wr_en, output, 1, registered write strobe to the FIFO.
REQ-009 SHALL have port fifo_data_in, output, FIFO_WIDTH, registered write data.
REQ-010 SHALL have ports fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow, input, 1 each, FIFO status.
REQ-011 SHALL have port err_drop, output, 1, one-cycle pulse on a missing wr_ack or asserted overflow.

Function
REQ-012 SHALL keep a 3-state FSM: IDLE (no req), ACTIVE (granting), STALL (back-pressured).
REQ-013 Transitions SHALL be: IDLE->ACTIVE on any req with space; any->STALL on no space; STALL->ACTIVE/IDLE on space, by req.
REQ-014 Space SHALL mean !fifo_full && !(fifo_almostfull && fifo_wr_en), which covers the write still in flight.
REQ-015 At most one grant bit SHALL be high per cycle, and only when space holds and req is non-zero.
REQ-016 Arbitration SHALL be round-robin: search starts at last_grant+1 mod NUM_REQ; last_grant updates only on a grant.
REQ-017 On grant[i], fifo_wr_en and fifo_data_in SHALL equal 1 and slice i on the next cycle (latency 1).
REQ-018 A requester holding req SHALL be granted within NUM_REQ granting cycles (no starvation).
REQ-019 If fifo_wr_en was 1 in cycle t and fifo_wr_ack is 0 in t+1, err_drop SHALL pulse in t+1.
REQ-020 fifo_overflow=1 SHALL also pulse err_drop that cycle; the arbiter SHALL never cause overflow with a compliant FIFO.
REQ-021 Requests deasserted without a grant SHALL be legal and silently dropped from arbitration.

Reset
REQ-022 While rst=1: grant=0, fifo_wr_en=0, fifo_data_in=0, err_drop=0, state=IDLE, last_grant=NUM_REQ-1 (req[0] first).
REQ-023 Reset asserted mid-operation SHALL cancel an in-flight write check; no err_drop for that write.

Configuration
REQ-024 With FIFO_ARB_STATS_EN defined, the block SHALL add a grant_cnt output of NUM_REQ*16 bits.
REQ-025 With the macro, each 16-bit counter SHALL count that requester's grants and saturate at 0xFFFF.
REQ-026 With the macro, the block SHALL add a 16-bit saturating drop_cnt output, incremented on err_drop; both counters clear on rst.
REQ-027 Without FIFO_ARB_STATS_EN, these ports and counters SHALL not exist, and behaviour SHALL be otherwise identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the FSM state enum (IDLE, ACTIVE, STALL), the default NUM_REQ/FIFO_WIDTH constants and the 16-bit stats width.
REQ-029 Round-robin selection SHALL be sub-module rr_pick (req vector and last index in, one-hot grant and index out, combinational).

Verification
REQ-030 After reset, req=4'b1111 with full=0 -> grants 0,1,2,3,0 on consecutive cycles; fifo_data_in follows 1 cycle later.
REQ-031 Only req[2] high with data 16'hA5A5 -> grant[2] in that cycle; next cycle fifo_wr_en=1 and fifo_data_in=16'hA5A5.
REQ-032 almostfull=1 while fifo_wr_en=1 -> no grant that cycle, state=STALL; space returns -> grant resumes in the same cycle.
REQ-033 fifo_full=1 for 10 cycles with req=4'b0101 -> grant=0 throughout; on release, grant[0] then grant[2].
REQ-034 Model drops wr_ack once after a write -> err_drop pulses exactly one cycle; with FIFO_ARB_STATS_EN, drop_cnt=1.
REQ-035 rst raised in the cycle after a grant -> fifo_wr_en=0 next cycle, no err_drop, req[0] has priority again.
